// File: rtl/alu_simd_pipe_pkg.sv
// Shared definitions for the SIMD ALU pipeline: opcode encodings and default lane geometry.
package alu_simd_pipe_pkg;

  localparam int DATA_WIDTH = 8;
  localparam int DEF_LANES  = 4;
  localparam int DEF_WIDTH  = DATA_WIDTH;
  localparam int OPCODE_W   = 4;

  typedef enum logic [OPCODE_W-1:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_MUL  = 4'd2,
    OP_CMP  = 4'd3,
    OP_ADDI = 4'd4,
    OP_SUBI = 4'd5
  } opcode_e;

endpackage

// File: rtl/alu_simd_pipe_lane.sv
// Single-lane combinational ALU: wrap/saturating add-sub, low-half multiply, signed/unsigned compare.
module alu_lane
  import alu_simd_pipe_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [OPCODE_W-1:0] i_opcode,
  input  logic                i_signed,
  input  logic                i_saturate,
  input  logic                i_enable,
  input  logic [WIDTH-1:0]    i_a,
  input  logic [WIDTH-1:0]    i_b,
  output logic [WIDTH-1:0]    o_result,
  output logic                o_cmp
);

  // One extra bit holds carry/borrow (unsigned) or the true sign (signed).
  logic [WIDTH:0]   w_ext_a, w_ext_b, w_sum, w_diff;
  logic [WIDTH-1:0] w_prod, w_max, w_min, w_sum_sat, w_diff_sat;
  logic             w_sum_ovf, w_diff_ovf;

  assign w_ext_a = {i_signed & i_a[WIDTH-1], i_a};
  assign w_ext_b = {i_signed & i_b[WIDTH-1], i_b};
  assign w_sum   = w_ext_a + w_ext_b;
  assign w_diff  = w_ext_a - w_ext_b;
  assign w_prod  = i_a * i_b;

  assign w_max = i_signed ? {1'b0, {(WIDTH-1){1'b1}}} : {WIDTH{1'b1}};
  assign w_min = i_signed ? {1'b1, {(WIDTH-1){1'b0}}} : {WIDTH{1'b0}};

  assign w_sum_ovf  = i_signed ? (w_sum[WIDTH] ^ w_sum[WIDTH-1])   : w_sum[WIDTH];
  assign w_diff_ovf = i_signed ? (w_diff[WIDTH] ^ w_diff[WIDTH-1]) : w_diff[WIDTH];
  assign w_sum_sat  = (i_signed && w_sum[WIDTH]) ? w_min : w_max;
  assign w_diff_sat = (!i_signed || w_diff[WIDTH]) ? w_min : w_max;

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
    o_result = '0;
    o_cmp    = 1'b0;
    if (i_enable) begin
      case (i_opcode)
        OP_ADD, OP_ADDI: o_result = (i_saturate && w_sum_ovf)  ? w_sum_sat  : w_sum[WIDTH-1:0];
        OP_SUB, OP_SUBI: o_result = (i_saturate && w_diff_ovf) ? w_diff_sat : w_diff[WIDTH-1:0];
        OP_MUL:          o_result = w_prod;
        OP_CMP:          o_cmp    = w_diff[WIDTH];
        default:         o_result = '0;
      endcase
    end
  end

endmodule

// File: rtl/alu_simd_pipe.sv
// Two-stage LANES-wide SIMD ALU with valid/ready handshake, backpressure and tag passthrough.
module alu_simd_pipe
  import alu_simd_pipe_pkg::*;
#(
  parameter int LANES    = DEF_LANES,
  parameter int WIDTH    = DEF_WIDTH,
  parameter int TAG_W    = 4,
  parameter bit SATURATE = 1'b0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [OPCODE_W-1:0]    in_opcode,
  input  logic                   in_signed,
  input  logic [LANES-1:0]       in_mask,
  input  logic [LANES*WIDTH-1:0] in_a,
  input  logic [LANES*WIDTH-1:0] in_b,
  input  logic [TAG_W-1:0]       in_tag,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*WIDTH-1:0] out_result,
  output logic [LANES-1:0]       out_cmp,
  output logic [LANES-1:0]       out_mask,
  output logic [TAG_W-1:0]       out_tag
);

  localparam int DW = LANES * WIDTH;

  logic                r_s1_valid;
  logic [OPCODE_W-1:0] r_s1_opcode;
  logic                r_s1_signed;
  logic [LANES-1:0]    r_s1_mask;
  logic [DW-1:0]       r_s1_a, r_s1_b;
  logic [TAG_W-1:0]    r_s1_tag;

  logic                r_s2_valid;
  logic [DW-1:0]       r_s2_result;
  logic [LANES-1:0]    r_s2_cmp, r_s2_mask;
  logic [TAG_W-1:0]    r_s2_tag;

  logic                w_adv1, w_adv2;
  logic [DW-1:0]       w_result;
  logic [LANES-1:0]    w_cmp;

  // Each stage moves when its successor is empty or draining, so bubbles collapse under stall.
  assign w_adv2   = !r_s2_valid || out_ready;
  assign w_adv1   = !r_s1_valid || w_adv2;
  assign in_ready = w_adv1;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    alu_lane #(.WIDTH(WIDTH)) u_lane (
      .i_opcode   (r_s1_opcode),
      .i_signed   (r_s1_signed),
      .i_saturate (SATURATE),
      .i_enable   (r_s1_mask[g]),
      .i_a        (r_s1_a[g*WIDTH +: WIDTH]),
      .i_b        (r_s1_b[g*WIDTH +: WIDTH]),
      .o_result   (w_result[g*WIDTH +: WIDTH]),
      .o_cmp      (w_cmp[g])
    );
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments let S2 capture S1's old contents while S1 reloads in the same edge.
    if (reset) begin
      // NOTE: the S2 payload drives the output ports, so it is cleared along with the valid bits.
      r_s1_valid  <= 1'b0;
      r_s1_opcode <= '0;
      r_s1_signed <= 1'b0;
      r_s1_mask   <= '0;
      r_s1_a      <= '0;
      r_s1_b      <= '0;
      r_s1_tag    <= '0;
      r_s2_valid  <= 1'b0;
      r_s2_result <= '0;
      r_s2_cmp    <= '0;
      r_s2_mask   <= '0;
      r_s2_tag    <= '0;
    end else begin
      if (w_adv1) begin
        r_s1_valid <= in_valid;
        if (in_valid) begin
          r_s1_opcode <= in_opcode;
          r_s1_signed <= in_signed;
          r_s1_mask   <= in_mask;
          r_s1_a      <= in_a;
          r_s1_b      <= in_b;
          r_s1_tag    <= in_tag;
        end
      end
      if (w_adv2) begin
        r_s2_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_s2_result <= w_result;
          r_s2_cmp    <= w_cmp;
          r_s2_mask   <= r_s1_mask;
          r_s2_tag    <= r_s1_tag;
        end
      end
    end
  end

  assign out_valid  = r_s2_valid;
  assign out_result = r_s2_result;
  assign out_cmp    = r_s2_cmp;
  assign out_mask   = r_s2_mask;
  assign out_tag    = r_s2_tag;

endmodule

// File: tb/tb_alu_simd_pipe.sv
// Self-checking bench: wrapping and saturating instances share stimulus; an arithmetic model scores every result.
module tb_alu_simd_pipe;
  import alu_simd_pipe_pkg::*;

  localparam int L  = 4;
  localparam int W  = 8;
  localparam int T  = 4;
  localparam int DW = L * W;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid, in_signed, out_ready;
  logic [3:0]    in_opcode;
  logic [L-1:0]  in_mask;
  logic [DW-1:0] in_a, in_b;
  logic [T-1:0]  in_tag;

  logic          in_ready, out_valid;
  logic [DW-1:0] out_result;
  logic [L-1:0]  out_cmp, out_mask;
  logic [T-1:0]  out_tag;

  logic          sat_in_ready, sat_out_valid;
  logic [DW-1:0] sat_result;
  logic [L-1:0]  sat_cmp, sat_mask;
  logic [T-1:0]  sat_tag;

  alu_simd_pipe #(.LANES(L), .WIDTH(W), .TAG_W(T), .SATURATE(1'b0)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_signed(in_signed), .in_mask(in_mask),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag), .out_valid(out_valid),
    .out_ready(out_ready), .out_result(out_result), .out_cmp(out_cmp),
    .out_mask(out_mask), .out_tag(out_tag)
  );

  alu_simd_pipe #(.LANES(L), .WIDTH(W), .TAG_W(T), .SATURATE(1'b1)) dut_sat (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(sat_in_ready),
    .in_opcode(in_opcode), .in_signed(in_signed), .in_mask(in_mask),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag), .out_valid(sat_out_valid),
    .out_ready(out_ready), .out_result(sat_result), .out_cmp(sat_cmp),
    .out_mask(sat_mask), .out_tag(sat_tag)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int n_out = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    logic [DW-1:0] res;
    logic [DW-1:0] res_sat;
    logic [L-1:0]  cmp;
    logic [L-1:0]  mask;
    logic [T-1:0]  tag;
  } exp_t;

  exp_t q[$];

  // Reference lane computed on integers: exact result, then clamp or keep the low bits.
  function automatic void lane_ref(input logic [3:0] op, input bit sgn, input bit sat,
                                   input logic [W-1:0] a, input logic [W-1:0] b,
                                   output logic [W-1:0] r, output logic c);
    int ua, ub, sa, sb, v, lo, hi;
    bit addsub;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    v = 0;
    c = 1'b0;
    addsub = 1'b0;
    case (op)
      OP_ADD, OP_ADDI: begin v = sgn ? sa + sb : ua + ub; addsub = 1'b1; end
      OP_SUB, OP_SUBI: begin v = sgn ? sa - sb : ua - ub; addsub = 1'b1; end
      OP_MUL:          v = ua * ub;
      OP_CMP:          c = sgn ? (sa < sb) : (ua < ub);
      default:         v = 0;
    endcase
    if (sat && addsub) begin
      lo = sgn ? -(1 << (W-1)) : 0;
      hi = sgn ? (1 << (W-1)) - 1 : (1 << W) - 1;
      if (v < lo) v = lo;
      if (v > hi) v = hi;
    end
    r = v[W-1:0];
  endfunction

  function automatic exp_t model(input logic [3:0] op, input bit sgn, input logic [L-1:0] m,
                                 input logic [DW-1:0] a, input logic [DW-1:0] b,
                                 input logic [T-1:0] tag);
    exp_t e;
    logic [W-1:0] r;
    logic c;
    e.res = '0; e.res_sat = '0; e.cmp = '0; e.mask = m; e.tag = tag;
    for (int i = 0; i < L; i++) begin
      if (m[i]) begin
        lane_ref(op, sgn, 1'b0, a[i*W +: W], b[i*W +: W], r, c);
        e.res[i*W +: W] = r;
        e.cmp[i] = c;
        lane_ref(op, sgn, 1'b1, a[i*W +: W], b[i*W +: W], r, c);
        e.res_sat[i*W +: W] = r;
      end
    end
    return e;
  endfunction

  // Scoreboard: predict on input transfer, compare on output transfer, and hold outputs steady while stalled.
  logic [DW-1:0] snap_res, snap_sat;
  logic [L-1:0]  snap_cmp, snap_mask;
  logic [T-1:0]  snap_tag;
  bit            snap_ok = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      q.delete();
      snap_ok = 1'b0;
    end else begin
      if (snap_ok) begin
        check("stall_valid",  64'(out_valid),  64'(1));
        check("stall_result", 64'(out_result), 64'(snap_res));
        check("stall_sat",    64'(sat_result), 64'(snap_sat));
        check("stall_cmp",    64'(out_cmp),    64'(snap_cmp));
        check("stall_mask",   64'(out_mask),   64'(snap_mask));
        check("stall_tag",    64'(out_tag),    64'(snap_tag));
      end
      if (out_valid && out_ready) begin
        n_out++;
        if (q.size() == 0) begin
          check("out_valid_without_request", 64'(out_valid), 64'(0));
        end else begin
          e = q.pop_front();
          check("result",     64'(out_result),    64'(e.res));
          check("sat_result", 64'(sat_result),    64'(e.res_sat));
          check("cmp",        64'(out_cmp),       64'(e.cmp));
          check("sat_cmp",    64'(sat_cmp),       64'(e.cmp));
          check("mask",       64'(out_mask),      64'(e.mask));
          check("tag",        64'(out_tag),       64'(e.tag));
          check("sat_tag",    64'(sat_tag),       64'(e.tag));
          check("sat_valid",  64'(sat_out_valid), 64'(1));
        end
      end
      if (in_valid && in_ready)
        q.push_back(model(in_opcode, in_signed, in_mask, in_a, in_b, in_tag));
      snap_ok   = out_valid && !out_ready;
      snap_res  = out_result;
      snap_sat  = sat_result;
      snap_cmp  = out_cmp;
      snap_mask = out_mask;
      snap_tag  = out_tag;
    end
  end

  function automatic logic [DW-1:0] pack4(input int l0, input int l1, input int l2, input int l3);
    logic [DW-1:0] p;
    p[7:0]   = l0[7:0];
    p[15:8]  = l1[7:0];
    p[23:16] = l2[7:0];
    p[31:24] = l3[7:0];
    return p;
  endfunction

  task automatic rand_req();
    in_opcode = ($urandom_range(0, 3) != 0) ? 4'($urandom_range(0, 5)) : 4'($urandom_range(0, 15));
    in_signed = 1'($urandom);
    in_mask   = L'($urandom);
    in_a      = DW'($urandom);
    in_b      = DW'($urandom);
    in_tag    = T'($urandom);
  endtask

  // Issue one request into an empty pipe and return at the negedge where its result is presented.
  task automatic run_one(input logic [3:0] op, input bit sgn, input logic [L-1:0] m,
                         input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic [T-1:0] tag, output int lat);
    in_opcode = op; in_signed = sgn; in_mask = m; in_a = a; in_b = b; in_tag = tag;
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    check("run_accept", 64'(in_ready), 64'(1));
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    @(negedge clk);
    while (!out_valid && lat < 20) begin
      lat++;
      @(negedge clk);
    end
  endtask

  initial begin
    int lat, sent, stall, n0;
    bit seen_ov, drop_checked, new_req, have;

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_opcode = '0; in_signed = 1'b0; in_mask = '0; in_a = '0; in_b = '0; in_tag = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_out_valid", 64'(out_valid),  64'(0));
    check("rst_in_ready",  64'(in_ready),   64'(1));
    check("rst_result",    64'(out_result), 64'(0));
    check("rst_tag",       64'(out_tag),    64'(0));
    @(posedge clk); #1;

    // ADD with wrap in lane 1 (200+100); saturating instance clamps it
    run_one(OP_ADD, 1'b0, 4'b1111, pack4(10, 200, 7, 0), pack4(5, 100, 3, 0), 4'hA, lat);
    check("add_latency",    64'(lat),        64'(2));
    check("add_result",     64'(out_result), 64'(pack4(15, 44, 10, 0)));
    check("add_sat_result", 64'(sat_result), 64'(pack4(15, 255, 10, 0)));
    check("add_cmp",        64'(out_cmp),    64'(0));
    check("add_tag",        64'(out_tag),    64'(4'hA));
    @(posedge clk); #1;

    run_one(OP_CMP, 1'b0, 4'b1111, pack4(8'hFF, 0, 0, 0), pack4(8'h01, 0, 0, 0), 4'h1, lat);
    check("cmp_u_ff_01", 64'(out_cmp), 64'(4'b0000));
    check("cmp_result",  64'(out_result), 64'(0));
    @(posedge clk); #1;
    run_one(OP_CMP, 1'b1, 4'b1111, pack4(8'hFF, 0, 0, 0), pack4(8'h01, 0, 0, 0), 4'h2, lat);
    check("cmp_s_ff_01", 64'(out_cmp), 64'(4'b0001));
    @(posedge clk); #1;
    run_one(OP_CMP, 1'b1, 4'b1111, pack4(8'h01, 0, 0, 0), pack4(8'hFF, 0, 0, 0), 4'h3, lat);
    check("cmp_s_01_ff", 64'(out_cmp), 64'(4'b0000));
    @(posedge clk); #1;
    run_one(OP_CMP, 1'b0, 4'b1111, pack4(8'h01, 0, 0, 0), pack4(8'hFF, 0, 0, 0), 4'h4, lat);
    check("cmp_u_01_ff", 64'(out_cmp), 64'(4'b0001));
    @(posedge clk); #1;

    run_one(OP_SUB, 1'b0, 4'b1111, pack4(5, 0, 0, 0), pack4(9, 0, 0, 0), 4'h5, lat);
    check("usub_wrap", 64'(out_result), 64'(pack4(252, 0, 0, 0)));
    check("usub_sat",  64'(sat_result), 64'(pack4(0, 0, 0, 0)));
    @(posedge clk); #1;
    run_one(OP_ADDI, 1'b1, 4'b1111, pack4(100, 0, 0, 0), pack4(100, 0, 0, 0), 4'h6, lat);
    check("sadd_wrap", 64'(out_result), 64'(pack4(200, 0, 0, 0)));
    check("sadd_sat",  64'(sat_result), 64'(pack4(127, 0, 0, 0)));
    @(posedge clk); #1;
    run_one(OP_SUBI, 1'b1, 4'b1111, pack4(8'h9C, 0, 0, 0), pack4(100, 0, 0, 0), 4'h7, lat);
    check("ssub_wrap", 64'(out_result), 64'(pack4(8'h38, 0, 0, 0)));
    check("ssub_sat",  64'(sat_result), 64'(pack4(8'h80, 0, 0, 0)));
    @(posedge clk); #1;
    run_one(OP_MUL, 1'b1, 4'b1111, pack4(16, 3, 0, 0), pack4(16, 5, 0, 0), 4'h8, lat);
    check("mul_wrap", 64'(out_result), 64'(pack4(0, 15, 0, 0)));
    check("mul_sat",  64'(sat_result), 64'(pack4(0, 15, 0, 0)));
    @(posedge clk); #1;

    run_one(OP_ADD, 1'b0, 4'b0101, pack4(1, 1, 1, 1), pack4(1, 1, 1, 1), 4'h9, lat);
    check("mask_result", 64'(out_result), 64'(pack4(2, 0, 2, 0)));
    check("mask_out",    64'(out_mask),   64'(4'b0101));
    @(posedge clk); #1;
    run_one(4'hF, 1'b0, 4'b1111, pack4(1, 2, 3, 4), pack4(9, 9, 9, 9), 4'hB, lat);
    check("illegal_result", 64'(out_result), 64'(0));
    check("illegal_cmp",    64'(out_cmp),    64'(0));
    @(posedge clk); #1;

    // Backpressure: six tagged requests, output stalled for five cycles once the first result appears
    sent = 0; stall = 0; seen_ov = 1'b0; drop_checked = 1'b0; new_req = 1'b1; n0 = n_out;
    out_ready = 1'b0;
    for (int cyc = 0; cyc < 60; cyc++) begin
      if (sent == 6 && q.size() == 0 && !out_valid) break;
      if (sent < 6) begin
        if (new_req) begin rand_req(); new_req = 1'b0; end
        in_tag = T'(sent);
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      out_ready = seen_ov && (stall >= 5);
      @(negedge clk);
      if (out_valid && !seen_ov) seen_ov = 1'b1;
      if (seen_ov && !out_ready) stall++;
      if (in_valid && !in_ready && !drop_checked) begin
        check("accepts_before_full", 64'(sent), 64'(2));
        drop_checked = 1'b1;
      end
      if (in_valid && in_ready) begin sent++; new_req = 1'b1; end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("bp_drained", 64'(q.size()),     64'(0));
    check("bp_outputs", 64'(n_out - n0),   64'(6));

    // Reset with two requests in flight and a new request offered in the same cycle
    out_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      rand_req(); in_opcode = OP_ADD; in_mask = 4'b1111; in_valid = 1'b1;
      @(negedge clk);
      @(posedge clk); #1;
    end
    rand_req(); in_valid = 1'b1; reset = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    check("mid_rst_valid",  64'(out_valid),  64'(0));
    check("mid_rst_ready",  64'(in_ready),   64'(1));
    check("mid_rst_result", 64'(out_result), 64'(0));
    check("mid_rst_cmp",    64'(out_cmp),    64'(0));
    check("mid_rst_mask",   64'(out_mask),   64'(0));
    check("mid_rst_tag",    64'(out_tag),    64'(0));
    check("mid_rst_sat",    64'(sat_result), 64'(0));
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("no_stale_valid", 64'(out_valid), 64'(0));
    end
    @(posedge clk); #1;

    // Randomized traffic with random backpressure
    sent = 0; have = 1'b0;
    for (int cyc = 0; cyc < 6000; cyc++) begin
      if (sent >= 300 && !have && q.size() == 0 && !out_valid) break;
      if (!have && sent < 300 && $urandom_range(0, 9) < 7) begin rand_req(); have = 1'b1; end
      in_valid  = have;
      out_ready = ($urandom_range(0, 9) < 7);
      @(negedge clk);
      if (in_valid && in_ready) begin have = 1'b0; sent++; end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("random_sent",    64'(sent),     64'(300));
    check("random_drained", 64'(q.size()), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
